// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between a CPU requester (m0) and a
// loader/debug requester (m1). Every transaction takes three cycles:
// IDLE (sample and latch the winner), ACCESS (one RAM strobe), DONE (ack the owner).
// Handshake: a requester raises a request by pulling rd_ or wr_ low and holds
// addr/d_out/strobe stable until it samples its ack high, then releases both
// strobes before the next rising edge. If rd_ and wr_ are both low, only the
// write is performed. Ties go to the requester that was not granted last.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_d_out,
  input  logic              m0_rd_,
  input  logic              m0_wr_,
  output logic [DATA_W-1:0] m0_d_in,
  output logic              m0_ack,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_d_out,
  input  logic              m1_rd_,
  input  logic              m1_wr_,
  output logic [DATA_W-1:0] m1_d_in,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d_out,
  output logic              ram_rd_,
  output logic              ram_wr_,
  input  logic [DATA_W-1:0] ram_d_in,
  output logic              busy,
  output logic [7:0]        m0_cnt,
  output logic [7:0]        m1_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_nx;
  logic   req0, req1;
  logic   win;         // 0 = m0, 1 = m1
  logic   win_wr;      // winner's operation is a write
  logic   owner;       // requester served by the current transaction
  logic   lat_wr;      // latched operation of the current transaction
  logic   last_grant;  // requester granted most recently
  logic   start;       // IDLE->ACCESS this cycle

  assign req0 = ~m0_rd_ | ~m0_wr_;
  assign req1 = ~m1_rd_ | ~m1_wr_;

  // Next-state, arbitration and output decode. ram_addr/ram_d_out are
  // registers loaded at grant time, so they keep their last value when idle.
  always_comb begin
    state_nx = state;
    win      = 1'b0;
    win_wr   = 1'b0;
    start    = 1'b0;
    ram_rd_  = 1'b1;
    ram_wr_  = 1'b1;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    busy     = (state != IDLE);
    win      = (req0 && req1) ? ~last_grant : ~req0;
    win_wr   = win ? ~m1_wr_ : ~m0_wr_;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nx = ACCESS;
          start    = 1'b1;
        end
      end
      ACCESS: begin
        state_nx = DONE;
        ram_wr_  = ~lat_wr;
        ram_rd_  = lat_wr;
      end
      DONE: begin
        state_nx = IDLE;
        m0_ack   = ~owner;
        m1_ack   = owner;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset drops straight to IDLE, which releases strobes/acks.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nx;
  end

  // Latch the winner's request and remember who was granted.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      owner      <= 1'b0;
      lat_wr     <= 1'b0;
      last_grant <= 1'b1;
      ram_addr   <= '0;
      ram_d_out  <= '0;
    end else if (start) begin
      owner      <= win;
      lat_wr     <= win_wr;
      last_grant <= win;
      ram_addr   <= win ? m1_addr  : m0_addr;
      ram_d_out  <= win ? m1_d_out : m0_d_out;
    end
  end

  // Capture read data into the owner's register at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m0_d_in <= '0;
      m1_d_in <= '0;
    end else if (state == ACCESS && !lat_wr) begin
      if (owner) m1_d_in <= ram_d_in;
      else       m0_d_in <= ram_d_in;
    end
  end

  // Count completed transactions at the end of DONE (aborted ones never count).
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m0_cnt <= 8'd0;
      m1_cnt <= 8'd0;
    end else if (state == DONE) begin
      if (owner) m1_cnt <= m1_cnt + 8'd1;
      else       m0_cnt <= m0_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM attached.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_;
  logic [7:0] m0_addr, m0_d_out, m0_d_in, m1_addr, m1_d_out, m1_d_in;
  logic       m0_rd_, m0_wr_, m0_ack, m1_rd_, m1_wr_, m1_ack;
  logic [7:0] ram_addr, ram_d_out, ram_d_in, m0_cnt, m1_cnt;
  logic       ram_rd_, ram_wr_, busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256] = '{default: 8'h00};

  // clock / RAM model
  always #5 clk = ~clk;
  assign ram_d_in = mem[ram_addr];
  always @(posedge clk) if (!ram_wr_) mem[ram_addr] <= ram_d_out;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_(rst_),
    .m0_addr(m0_addr), .m0_d_out(m0_d_out), .m0_rd_(m0_rd_), .m0_wr_(m0_wr_),
    .m0_d_in(m0_d_in), .m0_ack(m0_ack),
    .m1_addr(m1_addr), .m1_d_out(m1_d_out), .m1_rd_(m1_rd_), .m1_wr_(m1_wr_),
    .m1_d_in(m1_d_in), .m1_ack(m1_ack),
    .ram_addr(ram_addr), .ram_d_out(ram_d_out), .ram_rd_(ram_rd_), .ram_wr_(ram_wr_),
    .ram_d_in(ram_d_in), .busy(busy), .m0_cnt(m0_cnt), .m1_cnt(m1_cnt)
  );

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int m, input logic rd_n, input logic wr_n,
                         input logic [7:0] a, input logic [7:0] d);
    if (m == 0) begin
      m0_rd_ = rd_n; m0_wr_ = wr_n; m0_addr = a; m0_d_out = d;
    end else begin
      m1_rd_ = rd_n; m1_wr_ = wr_n; m1_addr = a; m1_d_out = d;
    end
  endtask

  task automatic clear_req(input int m);
    if (m == 0) begin m0_rd_ = 1'b1; m0_wr_ = 1'b1; end
    else        begin m1_rd_ = 1'b1; m1_wr_ = 1'b1; end
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    next_cycle();
    rst_ = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    checks++; if (ram_rd_ !== 1'b1 || ram_wr_ !== 1'b1) begin failures++; $display("FAIL reset_strobes: rd_=%b wr_=%b expected 1 1", ram_rd_, ram_wr_); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin failures++; $display("FAIL reset_acks: %b %b expected 0 0", m0_ack, m1_ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ram_addr !== 8'h00 || ram_d_out !== 8'h00) begin failures++; $display("FAIL reset_bus: addr=%h dout=%h expected 00 00", ram_addr, ram_d_out); end
    checks++; if (m0_d_in !== 8'h00 || m1_d_in !== 8'h00) begin failures++; $display("FAIL reset_d_in: %h %h expected 00 00", m0_d_in, m1_d_in); end
    checks++; if (m0_cnt !== 8'h00 || m1_cnt !== 8'h00) begin failures++; $display("FAIL reset_cnt: %h %h expected 00 00", m0_cnt, m1_cnt); end
    next_cycle();
    next_cycle();
    rst_ = 1'b1;
    next_cycle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset: busy=%b expected 0", busy); end
  endtask

  task automatic test_write();
    set_req(0, 1'b1, 1'b0, 8'h10, 8'hA5);
    next_cycle();
    checks++; if (ram_wr_ !== 1'b0 || ram_rd_ !== 1'b1) begin failures++; $display("FAIL write_strobe: wr_=%b rd_=%b expected 0 1", ram_wr_, ram_rd_); end
    checks++; if (ram_addr !== 8'h10 || ram_d_out !== 8'hA5) begin failures++; $display("FAIL write_bus: addr=%h dout=%h expected 10 a5", ram_addr, ram_d_out); end
    checks++; if (busy !== 1'b1 || m0_ack !== 1'b0) begin failures++; $display("FAIL write_access: busy=%b ack=%b expected 1 0", busy, m0_ack); end
    next_cycle();
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin failures++; $display("FAIL write_ack: m0=%b m1=%b expected 1 0", m0_ack, m1_ack); end
    checks++; if (ram_wr_ !== 1'b1) begin failures++; $display("FAIL write_strobe_done: wr_=%b expected 1", ram_wr_); end
    clear_req(0);
    next_cycle();
    checks++; if (m0_cnt !== 8'd1 || m1_cnt !== 8'd0) begin failures++; $display("FAIL write_cnt: m0=%0d m1=%0d expected 1 0", m0_cnt, m1_cnt); end
    checks++; if (m0_ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL write_idle: ack=%b busy=%b expected 0 0", m0_ack, busy); end
    checks++; if (ram_addr !== 8'h10 || ram_d_out !== 8'hA5) begin failures++; $display("FAIL write_hold: addr=%h dout=%h expected 10 a5", ram_addr, ram_d_out); end
    checks++; if (mem[8'h10] !== 8'hA5) begin failures++; $display("FAIL write_mem: got %h expected a5", mem[8'h10]); end
  endtask

  task automatic test_read();
    set_req(1, 1'b0, 1'b1, 8'h10, 8'h00);
    next_cycle();
    checks++; if (ram_rd_ !== 1'b0 || ram_wr_ !== 1'b1 || ram_addr !== 8'h10) begin failures++; $display("FAIL read_strobe: rd_=%b wr_=%b addr=%h expected 0 1 10", ram_rd_, ram_wr_, ram_addr); end
    next_cycle();
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin failures++; $display("FAIL read_ack: m1=%b m0=%b expected 1 0", m1_ack, m0_ack); end
    checks++; if (m1_d_in !== 8'hA5) begin failures++; $display("FAIL read_data: got %h expected a5", m1_d_in); end
    checks++; if (m0_d_in !== 8'h00) begin failures++; $display("FAIL read_other_d_in: got %h expected 00", m0_d_in); end
    clear_req(1);
    next_cycle();
    checks++; if (m1_cnt !== 8'd1 || m0_cnt !== 8'd1) begin failures++; $display("FAIL read_cnt: m1=%0d m0=%0d expected 1 1", m1_cnt, m0_cnt); end
  endtask

  task automatic test_rd_wr_both();
    set_req(0, 1'b0, 1'b0, 8'h22, 8'h5A);
    next_cycle();
    checks++; if (ram_wr_ !== 1'b0 || ram_rd_ !== 1'b1) begin failures++; $display("FAIL both_strobe: wr_=%b rd_=%b expected 0 1", ram_wr_, ram_rd_); end
    checks++; if (ram_addr !== 8'h22 || ram_d_out !== 8'h5A) begin failures++; $display("FAIL both_bus: addr=%h dout=%h expected 22 5a", ram_addr, ram_d_out); end
    next_cycle();
    checks++; if (m0_ack !== 1'b1 || ram_rd_ !== 1'b1) begin failures++; $display("FAIL both_ack: ack=%b rd_=%b expected 1 1", m0_ack, ram_rd_); end
    checks++; if (m0_d_in !== 8'h00 || m1_d_in !== 8'hA5) begin failures++; $display("FAIL both_d_in: m0=%h m1=%h expected 00 a5", m0_d_in, m1_d_in); end
    clear_req(0);
    next_cycle();
    checks++; if (mem[8'h22] !== 8'h5A) begin failures++; $display("FAIL both_mem: got %h expected 5a", mem[8'h22]); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         ec;
    logic [7:0] eo;
    do_reset();
    exp_q     = '{8'd0, 8'd1, 8'd0, 8'd1};
    exp_cyc_q = '{2, 5, 8, 11};
    set_req(0, 1'b1, 1'b0, 8'h40, 8'h11);
    set_req(1, 1'b1, 1'b0, 8'h41, 8'h22);
    for (int k = 1; k <= 12; k++) begin
      next_cycle();
      checks++; if (m0_ack && m1_ack) begin failures++; $display("FAIL rr_both_acks: cycle %0d m0=%b m1=%b expected not both", k, m0_ack, m1_ack); end
      if (m0_ack || m1_ack) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL rr_extra_ack: cycle %0d m1=%b expected none", k, m1_ack);
        end else begin
          eo = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          checks++; if ({7'd0, m1_ack} !== eo) begin failures++; $display("FAIL rr_order: cycle %0d got m%0d expected m%0d", k, m1_ack, eo); end
          checks++; if (k !== ec) begin failures++; $display("FAIL rr_timing: got cycle %0d expected %0d", k, ec); end
        end
      end
    end
    clear_req(0);
    clear_req(1);
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rr_missing: %0d grants outstanding expected 0", exp_q.size()); end
    checks++; if (m0_cnt !== 8'd2 || m1_cnt !== 8'd2) begin failures++; $display("FAIL rr_cnt: m0=%0d m1=%0d expected 2 2", m0_cnt, m1_cnt); end
    next_cycle();
    checks++; if (mem[8'h40] !== 8'h11 || mem[8'h41] !== 8'h22) begin failures++; $display("FAIL rr_mem: %h %h expected 11 22", mem[8'h40], mem[8'h41]); end
  endtask

  task automatic test_reset_mid_access();
    set_req(0, 1'b1, 1'b0, 8'h30, 8'h77);
    next_cycle();
    checks++; if (ram_wr_ !== 1'b0) begin failures++; $display("FAIL abort_setup: wr_=%b expected 0", ram_wr_); end
    rst_ = 1'b0;
    #1;
    checks++; if (ram_wr_ !== 1'b1 || ram_rd_ !== 1'b1) begin failures++; $display("FAIL abort_strobes: wr_=%b rd_=%b expected 1 1", ram_wr_, ram_rd_); end
    checks++; if (busy !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin failures++; $display("FAIL abort_state: busy=%b acks=%b%b expected 0 00", busy, m0_ack, m1_ack); end
    checks++; if (m0_cnt !== 8'd0 || m1_cnt !== 8'd0 || ram_addr !== 8'h00) begin failures++; $display("FAIL abort_regs: cnt=%0d/%0d addr=%h expected 0/0 00", m0_cnt, m1_cnt, ram_addr); end
    clear_req(0);
    next_cycle();
    next_cycle();
    rst_ = 1'b1;
    next_cycle();
    next_cycle();
    checks++; if (m0_ack !== 1'b0 || m0_cnt !== 8'd0) begin failures++; $display("FAIL abort_no_ack: ack=%b cnt=%0d expected 0 0", m0_ack, m0_cnt); end
    checks++; if (mem[8'h30] !== 8'h00) begin failures++; $display("FAIL abort_mem: got %h expected 00", mem[8'h30]); end
    set_req(1, 1'b0, 1'b1, 8'h10, 8'h00);
    next_cycle();
    next_cycle();
    checks++; if (m1_ack !== 1'b1 || m1_d_in !== 8'hA5) begin failures++; $display("FAIL abort_recover: ack=%b d_in=%h expected 1 a5", m1_ack, m1_d_in); end
    clear_req(1);
    next_cycle();
    checks++; if (m1_cnt !== 8'd1) begin failures++; $display("FAIL abort_recover_cnt: got %0d expected 1", m1_cnt); end
  endtask

  task automatic test_wrap();
    int miss = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      set_req(1, 1'b1, 1'b0, 8'(i), ~8'(i));
      next_cycle();
      next_cycle();
      if (m1_ack !== 1'b1) miss++;
      clear_req(1);
      next_cycle();
      if (i == 254) begin
        checks++; if (m1_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255: got %0d expected 255", m1_cnt); end
      end
    end
    checks++; if (miss !== 0) begin failures++; $display("FAIL wrap_acks: %0d missing expected 0", miss); end
    checks++; if (m1_cnt !== 8'd0) begin failures++; $display("FAIL wrap_cnt: got %0d expected 0", m1_cnt); end
    checks++; if (m0_cnt !== 8'd0) begin failures++; $display("FAIL wrap_m0_cnt: got %0d expected 0", m0_cnt); end
    checks++; if (mem[8'hFE] !== 8'h01) begin failures++; $display("FAIL wrap_mem: got %h expected 01", mem[8'hFE]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_ = 1'b0;
    m0_addr = 8'h00; m0_d_out = 8'h00; m0_rd_ = 1'b1; m0_wr_ = 1'b1;
    m1_addr = 8'h00; m1_d_out = 8'h00; m1_rd_ = 1'b1; m1_wr_ = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_rd_wr_both();
    test_round_robin();
    test_reset_mid_access();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
